seq_muldiv: RTL and testbench
=============================

# seq_muldiv

Parametrised sequential multiply/divide unit and successor to the fixed unsigned multiplier/divider pair. It performs one operation per transaction, selected by an opcode: unsigned or signed multiply, and unsigned or signed divide. It uses a valid/ready handshake on both the input and output sides, handles divide-by-zero explicitly, and holds its result until the consumer takes it. It sits beside the existing `seq_multiply`/`seq_divide` blocks as the shared arithmetic unit for pipelines that need signed ops and backpressure.

## Interface

Clocking and reset:
- Single clock `clk_i`.
- Reset `rst_i` is synchronous and active-high.

Parameters:
- `WidthA`, 32, multiplicand/dividend width (≥2)
- `WidthB`, 32, multiplier/divisor width (≥2)
- `WidthC`, localparam = `WidthA`+`WidthB`, product width

Ports:
- `clk_i` input 1: clock
- `rst_i` input 1: synchronous active-high reset
- `a_i` input `WidthA`: multiplicand / dividend
- `b_i` input `WidthB`: multiplier / divisor
- `op_i` input 2: `seq_op_e`: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- `valid_i` input 1: request valid
- `ready_o` output 1: unit idle, can accept
- `c_o` output `WidthC`: product (MUL ops), else 0
- `q_o` output `WidthA`: quotient (DIV ops), else 0
- `r_o` output `WidthB`: remainder (DIV ops), else 0
- `dbz_o` output 1: divide-by-zero flag for the current result
- `valid_o` output 1: result valid
- `ready_i` input 1: consumer accepts result

## Operation

Request capture:
- A request is accepted when `valid_i`&&`ready_o` at a rising edge.
- `a_i`, `b_i` and `op_i` are registered at accept and ignored afterwards.

State machine (`seq_state_e`):
- IDLE → CALC on accept. Exception: a DIV/DIVU with `b_i`==0 goes IDLE → FIX.
- CALC → FIX when the iteration counter reaches 0.
- FIX → DONE.
- DONE → IDLE on `ready_i`.

Signed operand handling:
- For signed ops, the operands are converted to magnitudes at accept.
- The negate flags are stored: product sign = sign(a)^sign(b), quotient sign = sign(a)^sign(b), remainder sign = sign(a).

Iteration:
- Radix-2, one bit per CALC cycle. N = `WidthB` for multiply (shift-add), N = `WidthA` for divide (restoring).
- The counter loads N-1 at accept.

FIX cycle:
- Applies two's-complement negation per the stored flags.
- Zeroes the outputs that are unused for the op class.
- Registers `c_o`/`q_o`/`r_o`/`dbz_o`.

Arithmetic rules:
- Divide truncates toward zero.
- Signed overflow (a = most negative, b = -1) gives q = a and r = 0. The magnitude path wraps naturally; no special case is needed.

Divide-by-zero:
- q = all ones, r = a[`WidthB`-1:0] (zero-extended if `WidthA`<`WidthB`), `dbz_o`=1.
- Applies to both signed and unsigned divide.

Output holding:
- Outputs remain stable while `valid_o`&&!`ready_i`.
- `ready_i` is ignored when `valid_o`=0.

## Timing

- Reset values: `ready_o`=1; all other outputs (`valid_o`, `c_o`, `q_o`, `r_o`, `dbz_o`) are 0. State is IDLE and the counter is 0.
- Cycle numbering: the accept cycle is cycle 0.
  - Normal op: CALC occupies cycles 1..N, FIX is cycle N+1, and `valid_o`=1 from cycle N+2. With default widths that is cycle 34.
  - Divide-by-zero: FIX is cycle 1 and `valid_o`=1 from cycle 2.
- `ready_o`=1 only in IDLE. After the output handshake there is one IDLE cycle before the next accept, so the minimum issue interval is N+3 cycles.
- `rst_i` asserted in any state returns the unit to IDLE and the reset values at the next edge. Any in-flight or held result is discarded.
- If `valid_i` is asserted on the same edge as `rst_i`, the request is not accepted.

## Structure

- Shared package `seq_pkg` holds:
  - `seq_op_e` (`OP_MULU`, `OP_MUL`, `OP_DIVU`, `OP_DIV`)
  - `seq_state_e` (`ST_IDLE`, `ST_CALC`, `ST_FIX`, `ST_DONE`)
  - helper function `is_div(op)`
- One sub-module, `seq_cond_negate #(Width)`: combinational conditional two's-complement negation. It is instantiated for operand magnitude conversion and for FIX-stage result sign correction.

## Test plan

All values use default widths.

1. MULU a=0xFFFF_FFFF, b=2 → c=0x1_FFFF_FFFE; `valid_o` rises in cycle 34; `q_o`=`r_o`=0.
2. MUL a=0xFFFF_FFFD (-3), b=7 → c=0xFFFF_FFFF_FFFF_FFEB (-21).
3. DIVU a=100, b=7 → q=14, r=2. DIV a=-7, b=2 → q=0xFFFF_FFFD, r=0xFFFF_FFFF. DIV a=0x8000_0000, b=0xFFFF_FFFF → q=0x8000_0000, r=0.
4. DIVU a=0x1234, b=0 → q=0xFFFF_FFFF, r=0x1234, `dbz_o`=1, `valid_o` in cycle 2. Same check for DIV.
5. Hold `ready_i`=0 for 5 cycles after `valid_o` → outputs stable, `ready_o`=0, new `valid_i` not accepted. Raise `ready_i` → `valid_o`=0 and `ready_o`=1 next cycle.
6. Assert `rst_i` in cycle 10 of a MULU → next cycle IDLE, all outputs at reset values. A following MULU 3×5 → c=15 at the correct latency.

Source files
------------

// File: rtl/seq_muldiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package seq_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

  function automatic logic is_div(seq_op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_signed_op(seq_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv_cond_negate.sv
// Combinational conditional two's-complement negation.
module seq_cond_negate #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] in_val,
  input  logic             neg,
  output logic [Width-1:0] out_val
);

  // Negate when requested, pass through otherwise
  always_comb begin
    if (neg) begin
      out_val = ~in_val + {{(Width-1){1'b0}}, 1'b1};
    end else begin
      out_val = in_val;
    end
  end

endmodule

// File: rtl/seq_muldiv.sv
// Radix-2 sequential multiply/divide unit, unsigned and signed, with
// valid/ready handshakes and explicit divide-by-zero handling.
module seq_muldiv
  import seq_pkg::*;
#(
  parameter int WidthA = 32,
  parameter int WidthB = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WidthA-1:0]        a_i,
  input  logic [WidthB-1:0]        b_i,
  input  seq_op_e                  op_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [WidthA+WidthB-1:0] c_o,
  output logic [WidthA-1:0]        q_o,
  output logic [WidthB-1:0]        r_o,
  output logic                     dbz_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int WidthC = WidthA + WidthB;
  localparam int WidthN = (WidthA > WidthB) ? WidthA : WidthB;
  localparam int CntW   = $clog2(WidthN);
  localparam logic [CntW-1:0] MulLast = CntW'(WidthB - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WidthA - 1);

  seq_state_e        state_r;
  seq_op_e           op_r;
  logic [CntW-1:0]   cnt_r;
  logic              neg_q_r, neg_r_r, dbz_flag_r;
  logic [WidthA-1:0] opa_r, quo_r;
  logic [WidthB-1:0] opb_r, rem_r;
  logic [WidthC-1:0] mul_r;

  logic              ready_r, valid_r, dbz_r;
  logic [WidthC-1:0] c_r;
  logic [WidthA-1:0] q_r;
  logic [WidthB-1:0] r_r;

  logic              a_neg_s, b_neg_s, b_zero_s;
  logic [WidthA-1:0] a_mag_s;
  logic [WidthB-1:0] b_mag_s, a_fit_s;
  logic [WidthC-1:0] c_fix_s;
  logic [WidthA-1:0] q_fix_s;
  logic [WidthB-1:0] r_fix_s;

  logic [WidthA-1:0] mul_add_s;
  logic [WidthA:0]   mul_sum_s;
  logic [WidthC-1:0] mul_next_s;
  logic [WidthB:0]   div_shift_s, div_diff_s;
  logic              div_ge_s;
  logic [WidthB-1:0] rem_next_s;
  logic [WidthA-1:0] quo_next_s;

  assign a_neg_s  = is_signed_op(op_i) & a_i[WidthA-1];
  assign b_neg_s  = is_signed_op(op_i) & b_i[WidthB-1];
  assign b_zero_s = (b_i == {WidthB{1'b0}});
  assign a_fit_s  = WidthB'(a_i);

  seq_cond_negate #(.Width(WidthA)) u_mag_a (.in_val(a_i), .neg(a_neg_s), .out_val(a_mag_s));
  seq_cond_negate #(.Width(WidthB)) u_mag_b (.in_val(b_i), .neg(b_neg_s), .out_val(b_mag_s));

  seq_cond_negate #(.Width(WidthC)) u_fix_c (.in_val(mul_r), .neg(neg_q_r), .out_val(c_fix_s));
  seq_cond_negate #(.Width(WidthA)) u_fix_q (.in_val(quo_r), .neg(neg_q_r), .out_val(q_fix_s));
  seq_cond_negate #(.Width(WidthB)) u_fix_r (.in_val(rem_r), .neg(neg_r_r), .out_val(r_fix_s));

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    if (mul_r[0]) begin
      mul_add_s = opa_r;
    end else begin
      mul_add_s = {WidthA{1'b0}};
    end
    mul_sum_s   = {1'b0, mul_r[WidthC-1:WidthB]} + {1'b0, mul_add_s};
    mul_next_s  = {mul_sum_s, mul_r[WidthB-1:1]};

    div_shift_s = {rem_r, quo_r[WidthA-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    div_ge_s    = ~div_diff_s[WidthB];
    if (div_ge_s) begin
      rem_next_s = div_diff_s[WidthB-1:0];
    end else begin
      rem_next_s = div_shift_s[WidthB-1:0];
    end
    quo_next_s  = {quo_r[WidthA-2:0], div_ge_s};
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_MULU;
      cnt_r      <= {CntW{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dbz_flag_r <= 1'b0;
      opa_r      <= {WidthA{1'b0}};
      quo_r      <= {WidthA{1'b0}};
      opb_r      <= {WidthB{1'b0}};
      rem_r      <= {WidthB{1'b0}};
      mul_r      <= {WidthC{1'b0}};
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      dbz_r      <= 1'b0;
      c_r        <= {WidthC{1'b0}};
      q_r        <= {WidthA{1'b0}};
      r_r        <= {WidthB{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_i && ready_r) begin
            op_r    <= op_i;
            opa_r   <= a_mag_s;
            opb_r   <= b_mag_s;
            mul_r   <= {{WidthA{1'b0}}, b_mag_s};
            ready_r <= 1'b0;
            if (is_div(op_i) && b_zero_s) begin
              // Result is fixed up front; FIX passes it through unmodified
              quo_r      <= {WidthA{1'b1}};
              rem_r      <= a_fit_s;
              neg_q_r    <= 1'b0;
              neg_r_r    <= 1'b0;
              dbz_flag_r <= 1'b1;
              cnt_r      <= {CntW{1'b0}};
              state_r    <= ST_FIX;
            end else begin
              quo_r      <= a_mag_s;
              rem_r      <= {WidthB{1'b0}};
              neg_q_r    <= a_neg_s ^ b_neg_s;
              neg_r_r    <= a_neg_s;
              dbz_flag_r <= 1'b0;
              cnt_r      <= is_div(op_i) ? DivLast : MulLast;
              state_r    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (is_div(op_r)) begin
            quo_r <= quo_next_s;
            rem_r <= rem_next_s;
          end else begin
            mul_r <= mul_next_s;
          end
          if (cnt_r == {CntW{1'b0}}) begin
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r - CntW'(1);
          end
        end
        ST_FIX: begin
          c_r     <= is_div(op_r) ? {WidthC{1'b0}} : c_fix_s;
          q_r     <= is_div(op_r) ? q_fix_s : {WidthA{1'b0}};
          r_r     <= is_div(op_r) ? r_fix_s : {WidthB{1'b0}};
          dbz_r   <= dbz_flag_r;
          valid_r <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_r;
  assign valid_o = valid_r;
  assign c_o     = c_r;
  assign q_o     = q_r;
  assign r_o     = r_r;
  assign dbz_o   = dbz_r;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: directed test-plan steps plus random
// operations checked against an arithmetic reference model.
module tb_seq_muldiv;
  import seq_pkg::*;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic [31:0] a_s, b_s;
  seq_op_e     op_s;
  logic        valid_s, ready_s;
  logic        ready_o_s, dbz_s, valid_o_s;
  logic [63:0] c_s;
  logic [31:0] q_s, r_s;

  int n_cmp = 0;
  int n_bad = 0;

  seq_muldiv #(.WidthA(32), .WidthB(32)) dut (
    .clk_i(clk_s), .rst_i(rst_s), .a_i(a_s), .b_i(b_s), .op_i(op_s),
    .valid_i(valid_s), .ready_o(ready_o_s), .c_o(c_s), .q_o(q_s), .r_o(r_s),
    .dbz_o(dbz_s), .valid_o(valid_o_s), .ready_i(ready_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions
  task automatic model(input seq_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] c, output logic [31:0] q,
                       output logic [31:0] r, output logic dbz);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 64'h0; q = 32'h0; r = 32'h0; dbz = 1'b0;
    case (op)
      OP_MULU: c = {32'h0, a} * {32'h0, b};
      OP_MUL:  c = 64'(sa * sb);
      OP_DIVU: if (b == 32'h0) begin dbz = 1'b1; q = 32'hFFFF_FFFF; r = a; end
               else begin q = a / b; r = a % b; end
      OP_DIV:  if (b == 32'h0) begin dbz = 1'b1; q = 32'hFFFF_FFFF; r = a; end
               else begin q = 32'(sa / sb); r = 32'(sa % sb); end
      default: c = 64'h0;
    endcase
  endtask

  task automatic run_op(input seq_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic poke);
    logic [63:0] ec;
    logic [31:0] eq, er;
    logic        edbz;
    int          k, lat;
    model(op, a, b, ec, eq, er, edbz);
    k = 0;
    while (ready_o_s !== 1'b1 && k < 100) begin @(posedge clk_s); #1; k++; end
    chk("ready_before_issue", 64'(ready_o_s), 64'h1);
    op_s = op; a_s = a; b_s = b; valid_s = 1'b1;
    @(posedge clk_s); #1;
    valid_s = 1'b0;
    a_s = $urandom; b_s = $urandom; op_s = seq_op_e'($urandom_range(0, 3));
    lat = 1;
    while (valid_o_s !== 1'b1 && lat < 100) begin @(posedge clk_s); #1; lat++; end
    chk("latency", 64'(lat), edbz ? 64'd2 : 64'd34);
    chk("c", c_s, ec);
    chk("q", 64'(q_s), 64'(eq));
    chk("r", 64'(r_s), 64'(er));
    chk("dbz", 64'(dbz_s), 64'(edbz));
    for (int i = 0; i < hold; i++) begin
      valid_s = poke;
      @(posedge clk_s); #1;
      chk("hold_valid", 64'(valid_o_s), 64'h1);
      chk("hold_ready", 64'(ready_o_s), 64'h0);
      chk("hold_c", c_s, ec);
      chk("hold_q", 64'(q_s), 64'(eq));
      chk("hold_r", 64'(r_s), 64'(er));
    end
    valid_s = 1'b0;
    ready_s = 1'b1;
    @(posedge clk_s); #1;
    ready_s = 1'b0;
    chk("after_hs_valid", 64'(valid_o_s), 64'h0);
    chk("after_hs_ready", 64'(ready_o_s), 64'h1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    seq_op_e     rop;
    int          sel;

    // Reset with a simultaneous request that must be ignored
    rst_s = 1'b1; valid_s = 1'b1; ready_s = 1'b0;
    a_s = 32'h5; b_s = 32'h6; op_s = OP_MULU;
    repeat (3) @(posedge clk_s);
    #1;
    rst_s = 1'b0; valid_s = 1'b0;
    chk("rst_ready", 64'(ready_o_s), 64'h1);
    chk("rst_valid", 64'(valid_o_s), 64'h0);
    chk("rst_c", c_s, 64'h0);
    chk("rst_q", 64'(q_s), 64'h0);
    chk("rst_r", 64'(r_s), 64'h0);
    chk("rst_dbz", 64'(dbz_s), 64'h0);

    // Directed test-plan operations
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'h2, 0, 1'b0);
    run_op(OP_MUL,  32'hFFFF_FFFD, 32'h7, 1, 1'b0);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIVU, 32'h1234, 32'h0, 0, 1'b0);
    run_op(OP_DIV,  32'h1234, 32'h0, 0, 1'b0);
    run_op(OP_DIV,  32'hFFFF_1234, 32'h0, 0, 1'b0);
    run_op(OP_MUL,  32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    // Backpressure with a competing request
    run_op(OP_DIV,  32'd55, 32'hFFFF_FFFB, 5, 1'b1);

    // Reset in cycle 10 of a multiply
    op_s = OP_MULU; a_s = 32'hDEAD_BEEF; b_s = 32'h1234_5678; valid_s = 1'b1;
    @(posedge clk_s); #1;
    valid_s = 1'b0;
    repeat (9) @(posedge clk_s);
    #1;
    rst_s = 1'b1; valid_s = 1'b1;
    @(posedge clk_s); #1;
    rst_s = 1'b0; valid_s = 1'b0;
    chk("midrst_ready", 64'(ready_o_s), 64'h1);
    chk("midrst_valid", 64'(valid_o_s), 64'h0);
    chk("midrst_c", c_s, 64'h0);
    chk("midrst_q", 64'(q_s), 64'h0);
    chk("midrst_r", 64'(r_s), 64'h0);
    chk("midrst_dbz", 64'(dbz_s), 64'h0);
    run_op(OP_MULU, 32'd3, 32'd5, 0, 1'b0);

    // Random operations including corner operands
    for (int n = 0; n < 24; n++) begin
      rop = seq_op_e'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      ra  = (sel == 3) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'h0;
        1:       rb = 32'h1;
        2, 3:    rb = 32'hFFFF_FFFF;
        4:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
